// File: rtl/ma_pkg.sv
// Shared types and constants for the memory-access stage.
// Used by memory_access_stage and ma_timeout_counter.
package ma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned RD_MSB = 25;
  localparam int unsigned RD_LSB = 22;

  localparam logic [RD_W-1:0]   RA_REG = 4'd15;
  localparam logic [DATA_W-1:0] PC_INC = 32'd4;

  // Calls link into the return-address register; everything else uses the rd field.
  function automatic logic [RD_W-1:0] resolve_rd(input logic iscall,
                                                 input logic [DATA_W-1:0] instr);
    return iscall ? RA_REG : instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] resolve_wb(input logic iscall,
                                                   input logic isld,
                                                   input logic [DATA_W-1:0] pc,
                                                   input logic [DATA_W-1:0] ldres,
                                                   input logic [DATA_W-1:0] alu);
    if (iscall)    return pc + PC_INC;
    else if (isld) return ldres;
    else           return alu;
  endfunction

endpackage

// File: rtl/ma_timeout_counter.sv
// Wait counter for the memory handshake; tc_c flags the cycle the limit is reached.
module ma_timeout_counter
  import ma_pkg::*;
#(
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc_c = en_i && (count_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access stage: request/ack data-memory access and resolved MA/RW bundle.
// Optional feature: define MA_TIMEOUT_EN to abort accesses that never get an ack.
module memory_access_stage
  import ma_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instruction,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_aluresult,
  input  logic [31:0]       in_op2,
  input  logic              in_isld,
  input  logic              in_isst,
  input  logic              in_iscall,
  input  logic              in_iswb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_instruction,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_aluresult,
  output logic [31:0]       out_ldresult,
  output logic              out_iswb,
  output logic [3:0]        out_rd,
  output logic [31:0]       out_wbdata,
  output logic              err_timeout
);

  state_e state_q, state_d;

  logic              in_ready_q, in_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Captured execute-latch fields for the in-flight memory instruction
  logic [31:0] cap_instr_q, cap_instr_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [31:0] cap_alu_q, cap_alu_d;
  logic        cap_isld_q, cap_isld_d;
  logic        cap_iscall_q, cap_iscall_d;
  logic        cap_wben_q, cap_wben_d;
  logic [31:0] ldres_q, ldres_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_alu_q, out_alu_d;
  logic [31:0] out_ldres_q, out_ldres_d;
  logic        out_iswb_q, out_iswb_d;
  logic [3:0]  out_rd_q, out_rd_d;
  logic [31:0] out_wbdata_q, out_wbdata_d;

`ifdef MA_TIMEOUT_EN
  logic err_q, err_d;
  logic timeout_c;

  ma_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_ACCESS),
    .clr_i (state_q != ST_ACCESS),
    .tc_c  (timeout_c)
  );
`endif

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cap_instr_d  = cap_instr_q;
    cap_pc_d     = cap_pc_q;
    cap_alu_d    = cap_alu_q;
    cap_isld_d   = cap_isld_q;
    cap_iscall_d = cap_iscall_q;
    cap_wben_d   = cap_wben_q;
    ldres_d      = ldres_q;
    out_valid_d  = 1'b0;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_alu_d    = out_alu_q;
    out_ldres_d  = out_ldres_q;
    out_iswb_d   = out_iswb_q;
    out_rd_d     = out_rd_q;
    out_wbdata_d = out_wbdata_q;
`ifdef MA_TIMEOUT_EN
    err_d        = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_isld || in_isst) begin
            // Store wins when both flags are set
            state_d      = ST_ACCESS;
            in_ready_d   = 1'b0;
            mem_req_d    = 1'b1;
            mem_we_d     = in_isst;
            mem_addr_d   = ADDR_W'({in_aluresult[31:2], 2'b00});
            mem_wdata_d  = in_op2;
            cap_instr_d  = in_instruction;
            cap_pc_d     = in_pc;
            cap_alu_d    = in_aluresult;
            cap_isld_d   = in_isld && !in_isst;
            cap_iscall_d = in_iscall;
            cap_wben_d   = in_iswb || in_iscall;
            ldres_d      = '0;
          end else begin
            out_valid_d  = 1'b1;
            out_instr_d  = in_instruction;
            out_pc_d     = in_pc;
            out_alu_d    = in_aluresult;
            out_ldres_d  = '0;
            out_iswb_d   = in_iswb || in_iscall;
            out_rd_d     = resolve_rd(in_iscall, in_instruction);
            out_wbdata_d = resolve_wb(in_iscall, 1'b0, in_pc, 32'd0, in_aluresult);
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          ldres_d     = cap_isld_q ? mem_rdata : 32'd0;
        end
`ifdef MA_TIMEOUT_EN
        else if (timeout_c) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          ldres_d     = '0;
          cap_wben_d  = 1'b0;
          err_d       = 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        in_ready_d   = 1'b1;
        out_valid_d  = 1'b1;
        out_instr_d  = cap_instr_q;
        out_pc_d     = cap_pc_q;
        out_alu_d    = cap_alu_q;
        out_ldres_d  = ldres_q;
        out_iswb_d   = cap_wben_q;
        out_rd_d     = resolve_rd(cap_iscall_q, cap_instr_q);
        out_wbdata_d = resolve_wb(cap_iscall_q, cap_isld_q, cap_pc_q, ldres_q, cap_alu_q);
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
        mem_req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cap_instr_q  <= '0;
      cap_pc_q     <= '0;
      cap_alu_q    <= '0;
      cap_isld_q   <= 1'b0;
      cap_iscall_q <= 1'b0;
      cap_wben_q   <= 1'b0;
      ldres_q      <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_alu_q    <= '0;
      out_ldres_q  <= '0;
      out_iswb_q   <= 1'b0;
      out_rd_q     <= '0;
      out_wbdata_q <= '0;
`ifdef MA_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cap_instr_q  <= cap_instr_d;
      cap_pc_q     <= cap_pc_d;
      cap_alu_q    <= cap_alu_d;
      cap_isld_q   <= cap_isld_d;
      cap_iscall_q <= cap_iscall_d;
      cap_wben_q   <= cap_wben_d;
      ldres_q      <= ldres_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_alu_q    <= out_alu_d;
      out_ldres_q  <= out_ldres_d;
      out_iswb_q   <= out_iswb_d;
      out_rd_q     <= out_rd_d;
      out_wbdata_q <= out_wbdata_d;
`ifdef MA_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign out_valid       = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_pc          = out_pc_q;
  assign out_aluresult   = out_alu_q;
  assign out_ldresult    = out_ldres_q;
  assign out_iswb        = out_iswb_q;
  assign out_rd          = out_rd_q;
  assign out_wbdata      = out_wbdata_q;
`ifdef MA_TIMEOUT_EN
  assign err_timeout     = err_q;
`else
  assign err_timeout     = 1'b0;
`endif

endmodule
